// File: rtl/fifo_wr_ctrl.sv
// Async FIFO write side: write pointers, full/almost-full/level
// and sticky overflow, all in the write clock domain.
module fifo_wr_ctrl #(
  parameter int DEPTH     = 8,
  parameter int AFULL_LVL = DEPTH - 2,
  localparam int A        = $clog2(DEPTH),
  localparam int W        = A + 1
) (
  input  logic         wclk,
  input  logic         wrst,
  input  logic         winc,
  input  logic [W-1:0] rptr_sync,
  input  logic         wovf_clr,
  output logic         wen,
  output logic [A-1:0] waddr,
  output logic [W-1:0] wptr,
  output logic         wfull,
  output logic         wafull,
  output logic [W-1:0] wlevel,
  output logic         wovf
);

  logic [W-1:0] wbin_q, wbin_d;
  logic [W-1:0] wgray_q, wgray_d;
  logic [W-1:0] lvl_q, lvl_d;
  logic         full_q, full_d;
  logic         afull_q, afull_d;
  logic         ovf_q, ovf_d;
  logic [W-1:0] rbin;
  logic [W-1:0] rfull_cmp;

  assign wen = winc & ~full_q;

  always_comb begin
    rbin    = '0;
    rbin[A] = rptr_sync[A];
    for (int i = A - 1; i >= 0; i--) begin
      rbin[i] = rbin[i+1] ^ rptr_sync[i];
    end
  end

  // Full when the write pointer is one lap ahead of the read pointer.
  assign rfull_cmp = {~rptr_sync[A:A-1], rptr_sync[A-2:0]};

  always_comb begin
    wbin_d  = wbin_q + W'(wen);
    wgray_d = (wbin_d >> 1) ^ wbin_d;
    full_d  = (wgray_d == rfull_cmp);
    lvl_d   = wbin_d - rbin;
    afull_d = (lvl_d >= W'(AFULL_LVL));
    ovf_d   = (winc & full_q) | (ovf_q & ~wovf_clr);
  end

  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      lvl_q   <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      lvl_q   <= lvl_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
    end
  end

  assign waddr  = wbin_q[A-1:0];
  assign wptr   = wgray_q;
  assign wfull  = full_q;
  assign wafull = afull_q;
  assign wlevel = lvl_q;
  assign wovf   = ovf_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Random and directed checks of fifo_wr_ctrl against an
// occupancy-count reference model.
module tb_fifo_wr_ctrl;

  localparam int DEPTH = 8;
  localparam int AF    = DEPTH - 2;
  localparam int A     = 3;
  localparam int W     = 4;

  logic         wclk = 1'b0;
  logic         wrst;
  logic         winc;
  logic [W-1:0] rptr_sync;
  logic         wovf_clr;
  logic         wen;
  logic [A-1:0] waddr;
  logic [W-1:0] wptr;
  logic         wfull;
  logic         wafull;
  logic [W-1:0] wlevel;
  logic         wovf;

  fifo_wr_ctrl #(.DEPTH(DEPTH), .AFULL_LVL(AF)) dut (
    .wclk(wclk), .wrst(wrst), .winc(winc),
    .rptr_sync(rptr_sync), .wovf_clr(wovf_clr),
    .wen(wen), .waddr(waddr), .wptr(wptr),
    .wfull(wfull), .wafull(wafull), .wlevel(wlevel),
    .wovf(wovf)
  );

  always #5 wclk = ~wclk;

  int nvec = 0;
  int nerr = 0;

  // model: total accepted writes and visible reads
  int nwr;
  int nrd;
  bit mfull;
  bit movf;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] gray(input int n);
    logic [W-1:0] b;
    b = W'(n % (2 * DEPTH));
    return b ^ (b >> 1);
  endfunction

  task automatic chk_all();
    int lvl;
    lvl = nwr - nrd;
    chk("wptr", 32'(wptr), 32'(gray(nwr)));
    chk("waddr", 32'(waddr), 32'(nwr % DEPTH));
    chk("wlevel", 32'(wlevel), 32'(lvl));
    chk("wfull", 32'(wfull), 32'(lvl == DEPTH));
    chk("wafull", 32'(wafull), 32'(lvl >= AF));
    chk("wovf", 32'(wovf), 32'(movf));
  endtask

  task automatic step(input bit w, input int r, input bit clr);
    bit acc;
    @(negedge wclk);
    winc      = w;
    rptr_sync = gray(r);
    wovf_clr  = clr;
    #1;
    chk("wen", 32'(wen), 32'(w && !mfull));
    @(posedge wclk);
    acc  = w && !mfull;
    movf = (w && mfull) || (movf && !clr);
    nwr  = nwr + int'(acc);
    nrd  = r;
    mfull = (nwr - nrd) == DEPTH;
    #1;
    chk_all();
  endtask

  task automatic do_reset();
    @(posedge wclk);
    #2;
    winc = 1'b1;
    wrst = 1'b0;
    #1;
    nwr = 0; nrd = 0; mfull = 0; movf = 0;
    chk("rst_wptr", 32'(wptr), 32'h0);
    chk("rst_waddr", 32'(waddr), 32'h0);
    chk("rst_wlevel", 32'(wlevel), 32'h0);
    chk("rst_wfull", 32'(wfull), 32'h0);
    chk("rst_wafull", 32'(wafull), 32'h0);
    chk("rst_wovf", 32'(wovf), 32'h0);
    @(negedge wclk);
    winc      = 1'b0;
    rptr_sync = '0;
    wrst      = 1'b1;
  endtask

  task automatic fill_check();
    logic [W-1:0] seq [8];
    seq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
            4'b0111, 4'b0101, 4'b0100, 4'b1100};
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 0, 1'b0);
      chk("fill_wptr", 32'(wptr), 32'(seq[i]));
      if (i == 5) chk("fill_afull6", 32'(wafull), 32'h1);
    end
    chk("fill_full8", 32'(wfull), 32'h1);
    chk("fill_lvl8", 32'(wlevel), 32'h8);
  endtask

  initial begin
    wrst      = 1'b0;
    winc      = 1'b0;
    rptr_sync = '0;
    wovf_clr  = 1'b0;
    nwr = 0; nrd = 0; mfull = 0; movf = 0;
    repeat (2) @(posedge wclk);
    @(negedge wclk);
    wrst = 1'b1;

    do_reset();
    fill_check();

    step(1'b1, 0, 1'b0);
    step(1'b1, 0, 1'b0);
    chk("ovf_wptr", 32'(wptr), 32'hC);
    chk("ovf_set", 32'(wovf), 32'h1);
    step(1'b0, 0, 1'b1);
    chk("ovf_clr", 32'(wovf), 32'h0);
    step(1'b1, 0, 1'b1);
    chk("ovf_setwins", 32'(wovf), 32'h1);

    step(1'b0, 3, 1'b0);
    chk("drain_full", 32'(wfull), 32'h0);
    chk("drain_lvl", 32'(wlevel), 32'h5);
    chk("drain_afull", 32'(wafull), 32'h0);
    step(1'b1, 3, 1'b0);
    chk("drain_lvl6", 32'(wlevel), 32'h6);
    chk("drain_afull6", 32'(wafull), 32'h1);

    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 0, 1'b0);
    do_reset();
    fill_check();

    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, (nwr > 0) ? nwr - 1 : 0, 1'b0);
      if (i > 0) chk("wrap_lvl2", 32'(wlevel), 32'h2);
      chk("wrap_nofull", 32'(wfull), 32'h0);
    end

    do_reset();
    for (int i = 0; i < 2000; i++) begin
      int r;
      r = nrd;
      if ($urandom_range(0, 2) == 0)
        r = nrd + int'($urandom_range(0, nwr - nrd));
      step(($urandom % 4) != 0, r, ($urandom % 8) == 0);
      if (i % 500 == 250) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
